// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, with valid/ready on both sides.
// Optional carry-in port enabled by defining SERIAL_ADDER_CIN_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             cin,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Half-adder cell: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q;
  logic [WIDTH-1:0] sum_sh_s;
  logic [CW-1:0]    cnt_q;
  logic             c_q, carry_q;
  logic [1:0]       ha1_s, ha2_s;
  logic             c_next_s, last_bit_s, cin_load_s;

`ifdef SERIAL_ADDER_CIN_EN
  assign cin_load_s = cin;
`else
  assign cin_load_s = 1'b0;
`endif

  assign ha1_s      = half_add(a_sh_q[0], b_sh_q[0]);
  assign ha2_s      = half_add(ha1_s[0], c_q);
  assign c_next_s   = ha1_s[1] | ha2_s[1];
  assign last_bit_s = (cnt_q == CW'(WIDTH - 1));

  // New sum bit enters at the MSB so the word is aligned after WIDTH shifts.
  always_comb begin
    sum_sh_s = sum_q >> 1'b1;
    sum_sh_s[WIDTH-1] = ha2_s[0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = RUN;  else state_d = IDLE;
      RUN:  if (last_bit_s) state_d = DONE; else state_d = RUN;
      DONE: if (out_ready) state_d = IDLE; else state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Operand shifters, running carry, bit counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      c_q     <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q <= A;
            b_sh_q <= B;
            c_q    <= cin_load_s;
            cnt_q  <= {CW{1'b0}};
          end
        end
        RUN: begin
          a_sh_q <= a_sh_q >> 1'b1;
          b_sh_q <= b_sh_q >> 1'b1;
          sum_q  <= sum_sh_s;
          c_q    <= c_next_s;
          cnt_q  <= cnt_q + CW'(1);
          if (last_bit_s) begin
            carry_q <= c_next_s;
          end
        end
        default: begin
          c_q <= c_q;
        end
      endcase
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed vectors push expected results,
// a negedge monitor pops and compares whenever a result is handed over.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, carry, cin_s;
  logic [7:0] A, B, sum;

  logic       in_valid1, in_ready1, out_valid1, carry1;
  logic [0:0] A1, B1, sum1;

  logic [8:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B),
`ifdef SERIAL_ADDER_CIN_EN
    .cin(cin_s),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry)
  );

  serial_adder #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(A1), .B(B1),
`ifdef SERIAL_ADDER_CIN_EN
    .cin(1'b0),
`endif
    .out_valid(out_valid1), .out_ready(1'b1), .sum(sum1), .carry(carry1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted result is matched against the scoreboard head.
  always @(negedge clk) begin
    logic [8:0] item;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got sum=%0h carry=%0b expected none", sum, carry);
      end else begin
        item = exp_q.pop_front();
        check("sum", {24'd0, sum}, {24'd0, item[7:0]});
        check("carry", {31'd0, carry}, {31'd0, item[8]});
      end
    end
  end

  // Waits for IDLE, presents one operand pair and returns just after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic exp_c, input logic [7:0] exp_s, input bit push);
    int k;
    @(negedge clk);
    for (k = 0; k < 40 && in_ready !== 1'b1; k++) @(negedge clk);
    check("idle_before_send", {31'd0, in_ready}, 32'd1);
    A = a; B = b; cin_s = ci; in_valid = 1'b1;
    if (push) exp_q.push_back({exp_c, exp_s});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    int lat;
    int cnt;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cin_s = 1'b0;
    A = 8'h00; B = 8'h00; in_valid1 = 1'b0; A1 = 1'b0; B1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_carry", {31'd0, carry}, 32'd0);

    // 1: zero operands, latency and in_ready during RUN
    send(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      lat = k;
      if (out_valid === 1'b1) break;
      check("in_ready_run", {31'd0, in_ready}, 32'd0);
    end
    check("latency", lat, 32'd8);

    // 2: full overflow
    send(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1);

    // 3: back-to-back with in_valid held high
    @(negedge clk);
    for (int k = 0; k < 40 && in_ready !== 1'b1; k++) @(negedge clk);
    A = 8'hA5; B = 8'h5A; in_valid = 1'b1;
    exp_q.push_back({1'b0, 8'hFF});
    @(posedge clk);
    #1 A = 8'h80; B = 8'h80;
    exp_q.push_back({1'b1, 8'h00});
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      cnt++;
    end
    check("busy_cycles", cnt, 32'd9);
    @(posedge clk);
    #1 in_valid = 1'b0;

    // 4: result held while out_ready is low
    @(negedge clk);
    for (int k = 0; k < 40 && in_ready !== 1'b1; k++) @(negedge clk);
    #1 out_ready = 1'b0;
    send(8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) break;
    end
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_sum", {24'd0, sum}, 32'h4B);
      check("hold_carry", {31'd0, carry}, 32'd0);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); @(negedge clk);
    check("idle_after_release", {31'd0, in_ready}, 32'd1);
    check("no_valid_after_release", {31'd0, out_valid}, 32'd0);

    // 5: reset on the third RUN edge aborts the operation
    send(8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_sum", {24'd0, sum}, 32'd0);
    check("abort_carry", {31'd0, carry}, 32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    check("abort_no_valid", seen, 32'd0);

    // Further patterns
    send(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b1);
    send(8'hF0, 8'hF0, 1'b0, 1'b1, 8'hE0, 1'b1);
    send(8'h55, 8'hAA, 1'b0, 1'b0, 8'hFF, 1'b1);
`ifdef SERIAL_ADDER_CIN_EN
    send(8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);
    send(8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b1);
`endif

    // WIDTH=1 instance: 1+1 in a single RUN cycle
    @(negedge clk);
    A1 = 1'b1; B1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("w1_valid", {31'd0, out_valid1}, 32'd1);
    check("w1_sum", {31'd0, sum1}, 32'd0);
    check("w1_carry", {31'd0, carry1}, 32'd1);

    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
